decoder_logic_unit: RTL

//  Parametrised, registered N-to-2^N decoder used as a programmable logic-function generator.

---
 rtl/decoder_logic_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decoder_logic_unit.sv
// ---------------------------------------------------------------------------
// decoder_logic_unit
//
// Registered N-to-2^N decoder used as a programmable logic-function generator.
// Every accepted select word produces its one-hot decode and f = TT[sel]. TT is
// a 2^N-bit truth-table register. Results leave through a 2-entry skid buffer
// with valid/ready on both sides. in_ready is decoded only from the state
// register, so there is no combinational path from out_ready to in_ready.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   cfg_we      in   1      write cfg_tt into TT on this edge
//   cfg_tt      in   OUT_W  new truth table (bit k = f(sel==k))
//   in_valid    in   1      in_sel is valid
//   in_ready    out  1      unit can accept (fewer than two entries held)
//   in_sel      in   SEL_W  select word
//   out_valid   out  1      head entry present
//   out_ready   in   1      downstream accepts the head entry
//   out_onehot  out  OUT_W  1 << sel of the head entry
//   out_f       out  1      TT[sel] captured when the entry was accepted
//   txn_cnt     out  CNT_W  saturating count of completed pops
// ---------------------------------------------------------------------------
module decoder_logic_unit #(
    parameter int                SEL_W      = 2,
    localparam int               OUT_W      = 1 << SEL_W,
    parameter logic [OUT_W-1:0]  DEFAULT_TT = {{(OUT_W-1){1'b0}}, 1'b1},
    parameter int                CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [OUT_W-1:0] cfg_tt,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_f,
    output logic [CNT_W-1:0] txn_cnt
);

    // The state encodes how many entries the buffer holds.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [OUT_W-1:0]   tt_r;
    logic [OUT_W-1:0]   main_onehot_r;
    logic               main_f_r;
    logic [OUT_W-1:0]   skid_onehot_r;
    logic               skid_f_r;
    logic [CNT_W-1:0]   txn_cnt_r;

    logic               accept_s;
    logic               pop_s;
    logic               load_new_s;
    logic               load_skid_s;
    logic               load_from_skid_s;
    logic [OUT_W-1:0]   new_onehot_s;
    logic               new_f_s;

    assign in_ready   = (state_r != ST_TWO);
    assign out_valid  = (state_r != ST_EMPTY);
    assign out_onehot = main_onehot_r;
    assign out_f      = main_f_r;
    assign txn_cnt    = txn_cnt_r;

    assign accept_s = in_valid && in_ready;
    assign pop_s    = out_valid && out_ready;

    // The entry reads TT as it was before this edge, so a same-cycle cfg_we
    // only affects accepts from the next cycle on.
    assign new_onehot_s = {{(OUT_W-1){1'b0}}, 1'b1} << in_sel;
    assign new_f_s      = tt_r[in_sel];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and buffer load controls.
    always_comb begin
        state_next_s     = state_r;
        load_new_s       = 1'b0;
        load_skid_s      = 1'b0;
        load_from_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_ONE;
                    load_new_s   = 1'b1;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && !pop_s) begin
                    state_next_s = ST_TWO;
                    load_skid_s  = 1'b1;
                end else if (pop_s && !accept_s) begin
                    state_next_s = ST_EMPTY;
                end else if (accept_s && pop_s) begin
                    state_next_s = ST_ONE;
                    load_new_s   = 1'b1;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can move the state.
                if (pop_s) begin
                    state_next_s     = ST_ONE;
                    load_from_skid_s = 1'b1;
                end else begin
                    state_next_s = ST_TWO;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Head (main) entry. It only changes on a load, so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_onehot_r <= {OUT_W{1'b0}};
            main_f_r      <= 1'b0;
        end else if (load_new_s) begin
            main_onehot_r <= new_onehot_s;
            main_f_r      <= new_f_s;
        end else if (load_from_skid_s) begin
            main_onehot_r <= skid_onehot_r;
            main_f_r      <= skid_f_r;
        end else begin
            main_onehot_r <= main_onehot_r;
            main_f_r      <= main_f_r;
        end
    end

    // Skid entry. It catches an accept that arrives while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_onehot_r <= {OUT_W{1'b0}};
            skid_f_r      <= 1'b0;
        end else if (load_skid_s) begin
            skid_onehot_r <= new_onehot_s;
            skid_f_r      <= new_f_s;
        end else begin
            skid_onehot_r <= skid_onehot_r;
            skid_f_r      <= skid_f_r;
        end
    end

    // Truth-table register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_r <= DEFAULT_TT;
        end else if (cfg_we) begin
            tt_r <= cfg_tt;
        end else begin
            tt_r <= tt_r;
        end
    end

    // Completed-transaction counter. It saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s && (txn_cnt_r != {CNT_W{1'b1}})) begin
            txn_cnt_r <= txn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            txn_cnt_r <= txn_cnt_r;
        end
    end

endmodule
